// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read-port to valid/ready stream with 3-entry latency buffer; FIFO_RD_CNT_EN adds WORD_CNT
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DRAIN_EN,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] R_DATA,
  output logic                  R_EN,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  WORD_CNT
`endif
);
  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0] occ, head, tail;
  logic infl, pop;
  // credit-based read issue: buffered plus in-flight words never exceed 3, independent of OUT_READY
  always_comb begin
    R_EN = !RST && DRAIN_EN && !EMPTY && (({1'b0, occ} + {2'b0, infl}) < 3'd3);
    OUT_VALID = !RST && (occ != 2'd0);
    BUSY = !RST && ((occ != 2'd0) || infl);
    pop = OUT_VALID && OUT_READY;
    OUT_DATA = mem[head];
  end
  // capture the in-flight word at the tail, pop the head, track occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      occ <= 2'd0;
      infl <= 1'b0;
      head <= 2'd0;
      tail <= 2'd0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      infl <= R_EN;
      occ <= occ + {1'b0, infl} - {1'b0, pop};
      if (infl) begin
        mem[tail] <= R_DATA;
        tail <= (tail == 2'd2) ? 2'd0 : tail + 2'd1;
      end
      if (pop) head <= (head == 2'd2) ? 2'd0 : head + 2'd1;
    end
  end
`ifdef FIFO_RD_CNT_EN
  // count every accepted handshake, wrapping naturally
  always_ff @(posedge CLK) begin
    if (RST) WORD_CNT <= '0;
    else if (pop) WORD_CNT <= WORD_CNT + 1'b1;
  end
`endif
endmodule
